matrix_test_system: RTL and testbench
=====================================

# matrix_test_system

Top-level UART matrix-multiply test system for the UNDron matrix bring-up. It receives two 2x2 unsigned 8-bit matrices over an 8N1 UART and computes their product. It transmits the four product elements back and toggles a status LED per completed job. It sits at FPGA top level, directly on the board clock, reset button, LED and UART pins.

## Interface
Parameters:
- clk_freq, 50_000_000, clock frequency in Hz.
- uart_baud_rate, 115200, UART bit rate. Bit period DIV = clk_freq / uart_baud_rate, integer truncation; must be ≥ 8.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-low (rst=0 resets).
- led  out 1  status LED; toggles once per completed matrix job.
- uart_rxd  in  1  UART receive line, idle high.
- uart_txd  out 1  UART transmit line, idle high.

## Operation
- Reset values: uart_txd=1, led=0, all counters/FSMs idle, RX byte buffer cleared.
- UART RX (8N1):
  - uart_rxd passes a 2-flop synchronizer.
  - A falling edge starts a frame; the line is re-sampled at DIV/2. If high, the start is false and RX returns to idle.
  - 8 data bits are sampled every DIV cycles, LSB first, then the stop bit.
  - Stop bit 0 is a framing error: the byte is discarded and RX returns to idle.
- UART TX (8N1): start bit 0, 8 data bits LSB first, stop bit 1, each held DIV cycles. It accepts a new byte only when idle.
- Control FSM states: BANNER, LOAD, COMPUTE, SEND.
  - BANNER: entered on reset release. Transmits one byte 0x3E ('>'), then goes to LOAD.
  - LOAD: stores received bytes in order a00,a01,a10,a11,b00,b01,b10,b11. The 8th byte moves to COMPUTE. Bytes arriving in COMPUTE/SEND are dropped.
  - COMPUTE: c_ij = a_i0*b_0j + a_i1*b_1j, unsigned, 17-bit result (max 130050). Sequential or parallel; must finish within 8 cycles.
  - SEND: transmits c00,c01,c10,c11, each as 3 bytes, MSB first: {7'b0,c[16]}, c[15:8], c[7:0]. 12 bytes, back-to-back, no idle gap beyond the TX stop bit. After the last stop bit: led toggles, load index clears, state returns to LOAD.
- No overflow is possible; no saturation logic.

## Timing
- Banner start bit begins within 4 cycles of the first clock with rst=1.
- A TX byte is exactly 10*DIV cycles.
- RX byte is valid 1 cycle after its stop-bit sample.
- From the stop-bit sample of byte 8 to the start bit of the first result byte: ≤ 10 cycles.
- A full job takes 20 RX frames' time (8 in, 12 out) plus ≤ 10 cycles of compute latency.
- Reset mid-operation (any state, mid-bit): next edge forces the reset values. The partial TX frame is aborted with the line high, partial matrices are lost, and BANNER reruns after release.
- Floating or constant-high uart_rxd: the system sits in LOAD forever after the banner, with no spurious bytes.
- Constant-low uart_rxd: produces framing errors only; no bytes are stored.

## Test plan
- Reset then idle, clk_freq=50e6, baud=1152000 (DIV=43): rst=0 for 4 cycles, then 1 -> uart_txd decodes one byte 0x3E in 430 cycles, then stays high; led stays 0 for 200000 cycles.
- Identity test: send A=[1,2;3,4], B=[1,0;0,1] -> TX bytes 00 00 01, 00 00 02, 00 00 03, 00 00 04; led becomes 1.
- Max values: A=B=all 0xFF -> each c = 130050 = 0x1FC02 -> four times 01 FC 02; led toggles again.
- Framing error: a byte with stop bit 0 inside the 8-byte load -> that byte is ignored, and the job completes only after 8 valid bytes.
- Glitch: a 10-cycle low pulse on uart_rxd -> no byte stored.
- Reset during SEND (after 5 result bytes): uart_txd goes high next cycle, led=0, 0x3E is resent, and a following fresh job produces correct results.

Source files
------------

// File: rtl/matrix_test_system.sv
// Purpose : UART-driven 2x2 8-bit matrix multiplier. Prints '>' after reset, loads A then B
//           (8 bytes), returns C = A*B as 4 x 3 bytes MSB first, and toggles led per job.
// Latency : result start bit <= 4 cycles after the stop-bit sample of the 8th input byte.
//           Backpressure: none on RX; bytes arriving while computing/sending are dropped.
// Ports   : clk, rst (sync, active-low), led, uart_rxd (idle high), uart_txd (idle high).
module matrix_test_system #(
    parameter int clk_freq       = 50_000_000,
    parameter int uart_baud_rate = 115200
) (
    input  logic clk,
    input  logic rst,
    output logic led,
    input  logic uart_rxd,
    output logic uart_txd
);

    localparam int DIV  = clk_freq / uart_baud_rate;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // ---------------------------------------------------------------- UART RX
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic            rxd_m_q, rxd_s_q, rxd_p_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_vld_q, rx_vld_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_vld_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                // Falling edge on the synchronised line opens a frame.
                if (rxd_p_q && !rxd_s_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    // Mid start bit: a high line means it was only a glitch.
                    rx_state_d = rxd_s_q ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                if (rx_cnt_q == CNT_LAST) begin
                    // A low stop bit is a framing error: the byte is silently dropped.
                    rx_state_d = RX_IDLE;
                    rx_vld_d   = rxd_s_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- UART TX
    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [8:0]    tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d;
    logic          tx_rdy;
    logic          tx_start;
    logic [7:0]    tx_byte;

    // Ready also in the final stop-bit cycle so consecutive frames abut with no idle gap.
    assign tx_rdy = !tx_busy_q || (tx_bit_q == 4'd9 && tx_cnt_q == CNT_LAST);

    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        if (tx_start && tx_rdy) begin
            tx_busy_d  = 1'b1;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_shift_d = {1'b1, tx_byte};
            txd_d      = 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == CNT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    txd_d     = 1'b1;
                end else begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
        end
    end

    // ---------------------------------------------------------------- control
    typedef enum logic [1:0] {ST_BANNER, ST_LOAD, ST_COMPUTE, ST_SEND} state_t;

    state_t      state_q, state_d;
    logic [2:0]  load_idx_q, load_idx_d;
    logic [7:0]  mat_q [8];     // a00,a01,a10,a11,b00,b01,b10,b11
    logic [7:0]  mat_d [8];
    logic [16:0] c_q [4];       // c00,c01,c10,c11
    logic [16:0] c_d [4];
    logic [1:0]  elem_q, elem_d;
    logic [1:0]  part_q, part_d;
    logic        send_done_q, send_done_d;
    logic        led_q, led_d;
    logic [16:0] cur_c;
    logic [7:0]  sel_byte;

    function automatic logic [16:0] mac(input logic [7:0] a0, input logic [7:0] b0,
                                        input logic [7:0] a1, input logic [7:0] b1);
        return {9'b0, a0} * {9'b0, b0} + {9'b0, a1} * {9'b0, b1};
    endfunction

    always_comb begin
        cur_c = c_q[elem_q];
        case (part_q)
            2'd0:    sel_byte = {7'b0, cur_c[16]};
            2'd1:    sel_byte = cur_c[15:8];
            default: sel_byte = cur_c[7:0];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        load_idx_d  = load_idx_q;
        mat_d       = mat_q;
        c_d         = c_q;
        elem_d      = elem_q;
        part_d      = part_q;
        send_done_d = send_done_q;
        led_d       = led_q;
        tx_start    = 1'b0;
        tx_byte     = 8'h3E;
        case (state_q)
            ST_BANNER: begin
                tx_start = 1'b1;
                if (tx_rdy) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (rx_vld_q) begin
                    mat_d[load_idx_q] = rx_shift_q;
                    load_idx_d        = load_idx_q + 3'd1;
                    if (load_idx_q == 3'd7) begin
                        state_d = ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                c_d[0]      = mac(mat_q[0], mat_q[4], mat_q[1], mat_q[6]);
                c_d[1]      = mac(mat_q[0], mat_q[5], mat_q[1], mat_q[7]);
                c_d[2]      = mac(mat_q[2], mat_q[4], mat_q[3], mat_q[6]);
                c_d[3]      = mac(mat_q[2], mat_q[5], mat_q[3], mat_q[7]);
                elem_d      = '0;
                part_d      = '0;
                send_done_d = 1'b0;
                state_d     = ST_SEND;
            end
            default: begin
                if (!send_done_q) begin
                    tx_start = 1'b1;
                    tx_byte  = sel_byte;
                    if (tx_rdy) begin
                        if (part_q == 2'd2) begin
                            part_d = '0;
                            if (elem_q == 2'd3) begin
                                send_done_d = 1'b1;
                            end else begin
                                elem_d = elem_q + 2'd1;
                            end
                        end else begin
                            part_d = part_q + 2'd1;
                        end
                    end
                end else if (tx_rdy) begin
                    // Last byte's stop bit is finishing: the job is complete.
                    led_d      = !led_q;
                    load_idx_d = '0;
                    state_d    = ST_LOAD;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_m_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_p_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_vld_q    <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '1;
            txd_q       <= 1'b1;
            state_q     <= ST_BANNER;
            load_idx_q  <= '0;
            mat_q       <= '{default: '0};
            c_q         <= '{default: '0};
            elem_q      <= '0;
            part_q      <= '0;
            send_done_q <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            rxd_m_q     <= uart_rxd;
            rxd_s_q     <= rxd_m_q;
            rxd_p_q     <= rxd_s_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_vld_q    <= rx_vld_d;
            tx_busy_q   <= tx_busy_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            txd_q       <= txd_d;
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            mat_q       <= mat_d;
            c_q         <= c_d;
            elem_q      <= elem_d;
            part_q      <= part_d;
            send_done_q <= send_done_d;
            led_q       <= led_d;
        end
    end

    assign uart_txd = txd_q;
    assign led      = led_q;

endmodule

// File: tb/tb_matrix_test_system.sv
// Purpose : directed bench for matrix_test_system at DIV = 50e6/1152000 = 43.
// Latency : UART frames are driven and decoded bit by bit, sampled on the falling clock edge.
// Backpressure: none; result decoding runs in parallel with input byte transmission.
module tb_matrix_test_system;

    localparam int DIV  = 43;
    localparam int HALF = 21;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic uart_rxd = 1'b1;
    logic led;
    logic uart_txd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matrix_test_system #(
        .clk_freq       (50_000_000),
        .uart_baud_rate (1_152_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .led      (led),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (DIV) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    // Bytes in transmit order, first byte in the top 8 bits.
    task automatic send_job(input logic [63:0] m);
        for (int i = 0; i < 8; i++) begin
            send_byte(m[63-8*i -: 8], 1'b1);
        end
    endtask

    // frame[0]=start, frame[8:1]=data, frame[9]=stop; all X on timeout.
    task automatic recv_byte(output logic [9:0] frame, output int wait_cyc);
        frame    = 'x;
        wait_cyc = 1;
        @(negedge clk);
        while (uart_txd !== 1'b0 && wait_cyc < 8000) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (uart_txd === 1'b0) begin
            repeat (HALF) @(negedge clk);
            frame[0] = uart_txd;
            for (int i = 1; i < 10; i++) begin
                repeat (DIV) @(negedge clk);
                frame[i] = uart_txd;
            end
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp, output int wait_cyc);
        logic [9:0] f;
        recv_byte(f, wait_cyc);
        check(tag, {22'b0, f}, {22'b0, 1'b1, exp, 1'b0});
    endtask

    task automatic expect_results(input string tag, input logic [16:0] c0, input logic [16:0] c1,
                                  input logic [16:0] c2, input logic [16:0] c3);
        logic [16:0] cs [4];
        int w;
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        for (int e = 0; e < 4; e++) begin
            expect_byte($sformatf("%s_c%0d_hi", tag, e), {7'b0, cs[e][16]}, w);
            expect_byte($sformatf("%s_c%0d_mid", tag, e), cs[e][15:8], w);
            expect_byte($sformatf("%s_c%0d_lo", tag, e), cs[e][7:0], w);
        end
    endtask

    initial begin
        int w;
        int viol;
        logic [9:0] f;

        // Reset state
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_txd", {31'b0, uart_txd}, 32'd1);
        check("reset_led", {31'b0, led}, 32'd0);

        // Banner right after release
        rst = 1'b1;
        expect_byte("banner", 8'h3E, w);
        check("banner_latency_ok", {31'b0, (w <= 4)}, 32'd1);

        // Idle: nothing more on the line, led stays off
        viol = 0;
        repeat (3000) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || led !== 1'b0) viol++;
        end
        check("idle_quiet", viol, 0);

        // Identity: A=[1,2;3,4], B=I
        fork
            send_job(64'h01_02_03_04_01_00_00_01);
            expect_results("ident", 17'd1, 17'd2, 17'd3, 17'd4);
        join
        repeat (40) @(negedge clk);
        check("ident_led", {31'b0, led}, 32'd1);

        // Maximum operands: every c = 2*255*255 = 0x1FC02
        fork
            send_job(64'hFF_FF_FF_FF_FF_FF_FF_FF);
            expect_results("max", 17'h1FC02, 17'h1FC02, 17'h1FC02, 17'h1FC02);
        join
        repeat (40) @(negedge clk);
        check("max_led", {31'b0, led}, 32'd0);

        // Framing error inside the load: A=[2,3;4,5], B=[6,7;8,9]
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h77, 1'b0);
        repeat (DIV) @(negedge clk);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h08, 1'b1);
        viol = 0;
        repeat (300) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) viol++;
        end
        check("frame_err_no_early_result", viol, 0);
        fork
            send_byte(8'h09, 1'b1);
            expect_results("frame_err", 17'd36, 17'd41, 17'd64, 17'd73);
        join
        repeat (40) @(negedge clk);
        check("frame_err_led", {31'b0, led}, 32'd1);

        // Reset in the middle of SEND, after five result bytes
        fork
            send_job(64'h01_02_03_04_01_00_00_01);
            begin
                expect_byte("rst_send_b0", 8'h00, w);
                expect_byte("rst_send_b1", 8'h00, w);
                expect_byte("rst_send_b2", 8'h01, w);
                expect_byte("rst_send_b3", 8'h00, w);
                expect_byte("rst_send_b4", 8'h00, w);
            end
        join
        repeat (30) @(negedge clk);
        check("rst_send_midframe_txd", {31'b0, uart_txd}, 32'd0);
        check("rst_send_led_before", {31'b0, led}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_send_txd_high", {31'b0, uart_txd}, 32'd1);
        check("rst_send_led_clear", {31'b0, led}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        recv_byte(f, w);
        check("rst_banner", {22'b0, f}, {22'b0, 1'b1, 8'h3E, 1'b0});
        check("rst_banner_latency_ok", {31'b0, (w <= 4)}, 32'd1);

        fork
            send_job(64'h02_03_04_05_06_07_08_09);
            expect_results("after_rst", 17'd36, 17'd41, 17'd64, 17'd73);
        join
        repeat (40) @(negedge clk);
        check("after_rst_led", {31'b0, led}, 32'd1);

        // Glitch mid-load: A=[10,20;30,40], B=[5,6;7,8]
        fork
            begin
                send_byte(8'd10, 1'b1);
                send_byte(8'd20, 1'b1);
                send_byte(8'd30, 1'b1);
                send_byte(8'd40, 1'b1);
                @(negedge clk);
                uart_rxd = 1'b0;
                repeat (10) @(negedge clk);
                uart_rxd = 1'b1;
                repeat (100) @(negedge clk);
                send_byte(8'd5, 1'b1);
                send_byte(8'd6, 1'b1);
                send_byte(8'd7, 1'b1);
                send_byte(8'd8, 1'b1);
            end
            expect_results("glitch", 17'd190, 17'd220, 17'd430, 17'd500);
        join
        repeat (40) @(negedge clk);
        check("glitch_led", {31'b0, led}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
